// File: rtl/cgra_dma_sched_pkg.sv
// Shared types for the CGRA DMA scheduler: FSM states and the descriptor layout.
package cgra_dma_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CMPL,
        S_HUNG
    } sched_state_t;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] size;
    } dma_desc_t;

    localparam int unsigned DMA_WORD_BYTES = 4;

endpackage

// File: rtl/cgra_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr_i,
// wrapping modulo N.
module cgra_rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx         = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IDX_W'((32'(ptr_i) + k) % N);
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_o[idx]  = 1'b1;
                gnt_idx_o   = idx;
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cgra_dma_scheduler.sv
// Round-robin front end sharing one CGRA DMA engine among NUM_REQ requesters,
// with launch pulse, busy/done tracking, watchdog and tagged completions.
module cgra_dma_scheduler
    import cgra_dma_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*32-1:0] req_src_i,
    input  logic [NUM_REQ*32-1:0] req_dst_i,
    input  logic [NUM_REQ*32-1:0] req_size_i,
    output logic [31:0]           cfg_src_o,
    output logic [31:0]           cfg_dst_o,
    output logic [31:0]           cfg_size_o,
    output logic                  cfg_start_o,
    input  logic                  status_busy_i,
    input  logic                  status_done_i,
    output logic                  cmpl_valid_o,
    output logic [ID_W-1:0]       cmpl_id_o,
    output logic                  cmpl_err_o,
    output logic                  irq_o,
    output logic                  sched_busy_o,
    output logic [31:0]           done_count_o
);

    sched_state_t     state_q, state_d;
    dma_desc_t        cfg_q, cfg_d;
    logic [ID_W-1:0]  cur_id_q, cur_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             err_q, err_d;
    logic             hung_q, hung_d;
    logic             irq_q;
    logic [31:0]      wdog_q, wdog_d;
    logic [31:0]      done_count_q, done_count_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_valid;
    dma_desc_t          win_desc;
    logic               timeout;

    cgra_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req_i       (req_valid_i),
        .ptr_i       (rr_ptr_q),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    always_comb begin
        win_desc = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt[i]) begin
                win_desc.src  = req_src_i[32*i +: 32];
                win_desc.dst  = req_dst_i[32*i +: 32];
                win_desc.size = req_size_i[32*i +: 32];
            end
        end
    end

    assign timeout = (TIMEOUT_CYCLES != 0) && (wdog_q >= TIMEOUT_CYCLES);

    // Done always wins over a same-cycle timeout; a timed-out transfer parks in
    // S_HUNG because the engine cannot be aborted.
    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        cur_id_d     = cur_id_q;
        rr_ptr_d     = rr_ptr_q;
        err_d        = err_q;
        hung_d       = hung_q;
        wdog_d       = wdog_q;
        done_count_d = done_count_q;
        req_ready_o  = '0;
        cfg_start_o  = 1'b0;
        cmpl_valid_o = 1'b0;
        cmpl_id_o    = '0;
        cmpl_err_o   = 1'b0;

        if ((state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) && wdog_q != '1) begin
            wdog_d = wdog_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (rst_n && gnt_valid) begin
                    req_ready_o = gnt;
                    cfg_d       = win_desc;
                    cur_id_d    = gnt_idx;
                    rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                    err_d       = 1'b0;
                    state_d     = (win_desc.size != 32'd0) ? S_START : S_CMPL;
                end
            end
            S_START: begin
                cfg_start_o = 1'b1;
                wdog_d      = '0;
                state_d     = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (status_done_i) begin
                    err_d   = 1'b0;
                    state_d = S_CMPL;
                end else if (status_busy_i) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (status_done_i) begin
                    err_d   = 1'b0;
                    state_d = S_CMPL;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    hung_d  = 1'b1;
                    state_d = S_CMPL;
                end
            end
            S_CMPL: begin
                cmpl_valid_o = 1'b1;
                cmpl_id_o    = cur_id_q;
                cmpl_err_o   = err_q;
                done_count_d = done_count_q + 32'd1;
                state_d      = hung_q ? S_HUNG : S_IDLE;
            end
            S_HUNG: begin
                if (!status_busy_i || status_done_i) begin
                    hung_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cfg_q        <= '0;
            cur_id_q     <= '0;
            rr_ptr_q     <= '0;
            err_q        <= 1'b0;
            hung_q       <= 1'b0;
            wdog_q       <= '0;
            done_count_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            cur_id_q     <= cur_id_d;
            rr_ptr_q     <= rr_ptr_d;
            err_q        <= err_d;
            hung_q       <= hung_d;
            wdog_q       <= wdog_d;
            done_count_q <= done_count_d;
            irq_q        <= cmpl_valid_o;
        end
    end

    assign cfg_src_o    = cfg_q.src;
    assign cfg_dst_o    = cfg_q.dst;
    assign cfg_size_o   = cfg_q.size;
    assign irq_o        = irq_q;
    assign sched_busy_o = (state_q != S_IDLE);
    assign done_count_o = done_count_q;

endmodule

// File: tb/tb_cgra_dma_scheduler.sv
// Scoreboard bench for cgra_dma_scheduler: directed descriptors, a small engine
// model, and a monitor checking launches and completions against expected queues.
module tb_cgra_dma_scheduler;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;
    localparam int TIMEOUT = 50;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] size;
    } desc_t;

    typedef struct {
        int id;
        bit err;
        bit zero;
    } cmpl_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_src = '0;
    logic [NUM_REQ*32-1:0] req_dst = '0;
    logic [NUM_REQ*32-1:0] req_size = '0;
    logic [31:0]           cfg_src, cfg_dst, cfg_size;
    logic                  cfg_start;
    logic                  status_busy = 1'b0;
    logic                  status_done = 1'b0;
    logic                  cmpl_valid;
    logic [ID_W-1:0]       cmpl_id;
    logic                  cmpl_err;
    logic                  irq;
    logic                  sched_busy;
    logic [31:0]           done_count;

    desc_t portQ0[$];
    desc_t portQ1[$];
    desc_t launchQ[$];
    cmpl_t cmplQ[$];

    int testsRun = 0;
    int testsFailed = 0;
    int cyc = 0;

    int  engMode = 0;
    int  engBusy = 20;
    bit  engRelease = 1'b0;

    cgra_dma_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .ID_W           (ID_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_src_i     (req_src),
        .req_dst_i     (req_dst),
        .req_size_i    (req_size),
        .cfg_src_o     (cfg_src),
        .cfg_dst_o     (cfg_dst),
        .cfg_size_o    (cfg_size),
        .cfg_start_o   (cfg_start),
        .status_busy_i (status_busy),
        .status_done_i (status_done),
        .cmpl_valid_o  (cmpl_valid),
        .cmpl_id_o     (cmpl_id),
        .cmpl_err_o    (cmpl_err),
        .irq_o         (irq),
        .sched_busy_o  (sched_busy),
        .done_count_o  (done_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNote(input string name, input string detail);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    task automatic applyStimulus(input int port, input logic [31:0] src, input logic [31:0] dst,
                                 input logic [31:0] size, input bit expErr);
        desc_t d;
        cmpl_t c;
        d.src  = src;
        d.dst  = dst;
        d.size = size;
        if (port == 0) portQ0.push_back(d);
        else           portQ1.push_back(d);
        if (size != 32'd0) launchQ.push_back(d);
        c.id   = port;
        c.err  = expErr;
        c.zero = (size == 32'd0);
        cmplQ.push_back(c);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_cfg_src"}, cfg_src, 32'd0);
        checkOutput({tag, "_cfg_dst"}, cfg_dst, 32'd0);
        checkOutput({tag, "_cfg_size"}, cfg_size, 32'd0);
        checkOutput({tag, "_cfg_start"}, 32'(cfg_start), 32'd0);
        checkOutput({tag, "_cmpl_valid"}, 32'(cmpl_valid), 32'd0);
        checkOutput({tag, "_cmpl_id"}, 32'(cmpl_id), 32'd0);
        checkOutput({tag, "_cmpl_err"}, 32'(cmpl_err), 32'd0);
        checkOutput({tag, "_irq"}, 32'(irq), 32'd0);
        checkOutput({tag, "_sched_busy"}, 32'(sched_busy), 32'd0);
        checkOutput({tag, "_done_count"}, done_count, 32'd0);
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(launchQ.size() == 0 && cmplQ.size() == 0 && portQ0.size() == 0 &&
                     portQ1.size() == 0 && !sched_busy && req_valid == '0) && n < budget);
        if (n >= budget) failNote(name, "scheduler did not drain within the cycle budget");
    endtask

    task automatic waitLaunch(input string name, input int budget);
        int n = 0;
        while (launchQ.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) failNote(name, "expected cfg_start never seen");
    endtask

    task automatic waitCmplLeft(input string name, input int left, input int budget);
        int n = 0;
        while (cmplQ.size() > left && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) failNote(name, "expected completion never seen");
    endtask

    // Requester driver: holds each queued descriptor valid until its handshake.
    initial begin
        logic [NUM_REQ-1:0] hs;
        forever begin
            @(negedge clk);
            hs = rst_n ? (req_valid & req_ready) : '0;
            @(posedge clk);
            #1;
            if (hs[0] && portQ0.size() > 0) void'(portQ0.pop_front());
            if (hs[1] && portQ1.size() > 0) void'(portQ1.pop_front());
            req_valid[0] = (portQ0.size() > 0);
            req_valid[1] = (portQ1.size() > 0);
            if (portQ0.size() > 0) begin
                req_src[31:0]  = portQ0[0].src;
                req_dst[31:0]  = portQ0[0].dst;
                req_size[31:0] = portQ0[0].size;
            end
            if (portQ1.size() > 0) begin
                req_src[63:32]  = portQ1[0].src;
                req_dst[63:32]  = portQ1[0].dst;
                req_size[63:32] = portQ1[0].size;
            end
        end
    end

    // Engine model: busy for engBusy cycles then a done pulse, or busy until released.
    initial begin
        bit startSeen;
        bit hanging;
        int remain;
        hanging = 1'b0;
        remain  = 0;
        forever begin
            @(negedge clk);
            startSeen = cfg_start && rst_n;
            @(posedge clk);
            #1;
            status_done = 1'b0;
            if (!rst_n) begin
                status_busy = 1'b0;
                hanging     = 1'b0;
                remain      = 0;
            end else if (startSeen) begin
                status_busy = 1'b1;
                if (engMode == 1) hanging = 1'b1;
                else              remain  = engBusy;
            end else if (hanging) begin
                if (engRelease) begin
                    status_busy = 1'b0;
                    status_done = 1'b1;
                    hanging     = 1'b0;
                end
            end else if (remain > 0) begin
                remain--;
                if (remain == 0) begin
                    status_busy = 1'b0;
                    status_done = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT launches or completes.
    initial begin
        bit    prevCmpl;
        bit    postPending;
        bit    postBusy;
        int    hsCycle;
        int    startCycle;
        int    doneCycle;
        desc_t d;
        cmpl_t c;
        prevCmpl = 1'b0;
        postPending = 1'b0;
        postBusy = 1'b0;
        hsCycle = 0;
        startCycle = 0;
        doneCycle = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                launchQ.delete();
                cmplQ.delete();
                prevCmpl = 1'b0;
                postPending = 1'b0;
            end else begin
                checkOutput("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
                checkOutput("irq_follows_cmpl", 32'(irq), 32'(prevCmpl));
                prevCmpl = cmpl_valid;
                if (postPending) begin
                    checkOutput("busy_after_cmpl", 32'(sched_busy), 32'(postBusy));
                    postPending = 1'b0;
                end
                if (|(req_valid & req_ready)) hsCycle = cyc;
                if (cfg_start) begin
                    if (launchQ.size() == 0) begin
                        failNote("unexpected_start", $sformatf("cfg_start at cycle %0d with no launch expected", cyc));
                    end else begin
                        d = launchQ.pop_front();
                        checkOutput("cfg_src", cfg_src, d.src);
                        checkOutput("cfg_dst", cfg_dst, d.dst);
                        checkOutput("cfg_size", cfg_size, d.size);
                        checkOutput("launch_latency", 32'(cyc - hsCycle), 32'd1);
                    end
                    startCycle = cyc;
                end
                if (cmpl_valid) begin
                    if (cmplQ.size() == 0) begin
                        failNote("unexpected_cmpl", $sformatf("cmpl_valid at cycle %0d id=%0d with none expected", cyc, cmpl_id));
                    end else begin
                        c = cmplQ.pop_front();
                        checkOutput("cmpl_id", 32'(cmpl_id), 32'(c.id));
                        checkOutput("cmpl_err", 32'(cmpl_err), 32'(c.err));
                        if (c.zero)
                            checkOutput("zero_size_latency", 32'(cyc - hsCycle), 32'd1);
                        else if (c.err)
                            checkOutput("timeout_latency_in_50_to_53",
                                        32'((cyc - startCycle >= 50) && (cyc - startCycle <= 53)), 32'd1);
                        else
                            checkOutput("cmpl_latency", 32'(cyc - doneCycle), 32'd1);
                        postPending = 1'b1;
                        postBusy    = c.err;
                    end
                end
                if (status_done) doneCycle = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "[TB] aborted");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single request on port 0 with a 20-cycle engine.
        engMode = 0;
        engBusy = 20;
        applyStimulus(0, 32'h0000_1000, 32'h0000_2000, 32'd16, 1'b0);
        waitIdle("wait_single", 300);
        checkOutput("done_count_single", done_count, 32'd1);

        // Zero-size on port 1: no launch, completion one cycle after handshake.
        applyStimulus(1, 32'h1111_0000, 32'h2222_0000, 32'd0, 1'b0);
        waitIdle("wait_zero", 50);
        checkOutput("done_count_zero", done_count, 32'd2);
        checkOutput("cfg_src_zero_latched", cfg_src, 32'h1111_0000);
        checkOutput("cfg_size_zero_latched", cfg_size, 32'd0);

        // Fairness: both ports hold four descriptors; launches must alternate 0,1,0,1.
        engBusy = 3;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 32'h0000_A000 + 32'(i * 256), 32'h0000_B000 + 32'(i * 256), 32'(4 * (i + 1)), 1'b0);
            applyStimulus(1, 32'h0000_C000 + 32'(i * 256), 32'h0000_D000 + 32'(i * 256), 32'(8 * (i + 1)), 1'b0);
        end
        waitIdle("wait_fair", 2000);
        checkOutput("done_count_fair", done_count, 32'd10);

        // Timeout: engine stays busy, port 1 queued behind the hung transfer.
        engMode = 1;
        applyStimulus(0, 32'h0000_3000, 32'h0000_4000, 32'd64, 1'b1);
        waitLaunch("wait_hang_launch", 100);
        applyStimulus(1, 32'h0000_5000, 32'h0000_6000, 32'd32, 1'b0);
        waitCmplLeft("wait_timeout_cmpl", 1, 200);
        repeat (10) @(negedge clk);
        checkOutput("hung_sched_busy", 32'(sched_busy), 32'd1);
        checkOutput("hung_port1_waiting", 32'(portQ1.size()), 32'd1);
        engMode = 0;
        engBusy = 5;
        engRelease = 1'b1;
        @(negedge clk);
        engRelease = 1'b0;
        waitIdle("wait_after_hang", 300);
        checkOutput("done_count_timeout", done_count, 32'd12);

        // Done lands on the timeout cycle: must finish clean and return to idle.
        engBusy = TIMEOUT;
        applyStimulus(0, 32'h0000_7000, 32'h0000_8000, 32'd128, 1'b0);
        waitIdle("wait_collision", 300);
        checkOutput("done_count_collision", done_count, 32'd13);

        // Reset while waiting on the engine, then a normal transfer.
        engMode = 1;
        applyStimulus(1, 32'h0000_9000, 32'h0000_9100, 32'd256, 1'b0);
        waitLaunch("wait_rst_launch", 100);
        repeat (5) @(negedge clk);
        checkOutput("pre_reset_busy", 32'(sched_busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkResetValues("mid_reset");
        rst_n = 1'b1;
        engMode = 0;
        engBusy = 4;
        @(negedge clk);
        applyStimulus(0, 32'h0000_E000, 32'h0000_F000, 32'd12, 1'b0);
        waitIdle("wait_post_reset", 200);
        checkOutput("done_count_post_reset", done_count, 32'd1);

        checkOutput("cmpl_queue_drained", 32'(cmplQ.size()), 32'd0);
        checkOutput("launch_queue_drained", 32'(launchQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
